// File: rtl/spi_slave_byte_if_if.sv
// Byte handshake between the SPI slave PHY and the SPI command controller.
interface spi_slave_byte_if_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;

    modport master (
        input  rx_data, rx_valid, tx_done,
        output tx_data, tx_ready
    );

    modport slave (
        output rx_data, rx_valid, tx_done,
        input  tx_data, tx_ready
    );
endinterface

// File: rtl/spi_slave_byte_if.sv
// SPI mode 0 byte-level slave PHY: oversampled pins, MSB-first deserialiser
// and serialiser, byte handshake toward the command controller.
module spi_slave_byte_if #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                mosi,
    input  logic                cs_n,
    output logic                miso,
    output logic                miso_oe,
    output logic                cs_active,
    spi_slave_byte_if_if.slave  bus
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, flush;
    logic                   sclk_hist, cs_hist, seen_high;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                   slot_start, abort, shift_rx, shift_tx;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_shift, tx_shift;
    logic                   loaded;
    logic                   byte_end_p1, done_p1;

    // Stage p0: pin synchronisers and edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_hist <= 1'b0;
            cs_hist   <= 1'b1;
            flush     <= '0;
            seen_high <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            cs_hist   <= cs_sync[SYNC_STAGES-1];
            flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
            // A frame may only start after cs_n has been genuinely seen high,
            // so cs_n held low across reset release never opens a frame.
            if (flush[SYNC_STAGES-1] && cs_sync[SYNC_STAGES-1])
                seen_high <= 1'b1;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign cs_fall   = ~cs_s & cs_hist & seen_high;
    assign cs_rise   = cs_s & ~cs_hist;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // cs rise takes priority over any coincident sclk edge
    always_comb begin
        state_next = state;
        slot_start = 1'b0;
        abort      = 1'b0;
        shift_rx   = 1'b0;
        shift_tx   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                    slot_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else if (sclk_rise) begin
                    shift_rx = 1'b1;
                end else if (sclk_fall) begin
                    if (bit_cnt == 3'd0) slot_start = 1'b1;
                    else                 shift_tx   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p1: shift registers and byte-end flags
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            loaded      <= 1'b0;
            byte_end_p1 <= 1'b0;
            done_p1     <= 1'b0;
        end else begin
            byte_end_p1 <= 1'b0;
            done_p1     <= 1'b0;
            if (slot_start) begin
                bit_cnt  <= 3'd0;
                tx_shift <= bus.tx_ready ? bus.tx_data : FILL_BYTE;
                loaded   <= bus.tx_ready;
            end else if (abort) begin
                bit_cnt  <= 3'd0;
                tx_shift <= 8'h00;
                loaded   <= 1'b0;
            end else if (shift_rx) begin
                rx_shift <= {rx_shift[6:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_end_p1 <= 1'b1;
                    done_p1     <= loaded;
                end
            end else if (shift_tx) begin
                tx_shift <= tx_shift << 1;
            end
        end
    end

    // Stage p2: byte handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rx_data  <= 8'h00;
            bus.rx_valid <= 1'b0;
            bus.tx_done  <= 1'b0;
        end else begin
            bus.rx_valid <= byte_end_p1;
            bus.tx_done  <= done_p1;
            if (byte_end_p1) bus.rx_data <= rx_shift;
        end
    end

    assign cs_active = (state == ACTIVE);
    assign miso_oe   = cs_active;
    assign miso      = cs_active & tx_shift[7];

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Bench for spi_slave_byte_if: table of frames plus hand-written abort/reset
// sequences; received bytes are scoreboarded against a queue of expectations.
module tb_spi_slave_byte_if;

    localparam int         SYNC = 2;
    localparam logic [7:0] FILL = 8'h00;
    localparam int         HALF = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       done;
    } exp_t;

    typedef struct packed {
        logic [1:0]      n;
        logic [2:0][7:0] mosi;
        logic [2:0][7:0] tx;
        logic [2:0]      txv;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic cs_n = 1'b1;
    logic miso, miso_oe, cs_active;

    spi_slave_byte_if_if bus();

    spi_slave_byte_if #(.SYNC_STAGES(SYNC), .FILL_BYTE(FILL)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .miso_oe(miso_oe), .cs_active(cs_active), .bus(bus)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    exp_t   sb[$];
    frame_t cur;
    frame_t tbl[5];
    int     rx_idx;
    logic   rv_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic frame_t mk(input int n, input logic [7:0] m0, m1, m2,
                                  input logic [7:0] t1, input logic v1,
                                  input logic [7:0] t2, input logic v2);
        frame_t f;
        f.n       = 2'(n);
        f.mosi[0] = m0;  f.mosi[1] = m1;  f.mosi[2] = m2;
        f.tx[0]   = 8'h00; f.tx[1] = t1;  f.tx[2]   = t2;
        f.txv     = {v2, v1, 1'b0};
        return f;
    endfunction

    // Controller model: offers the next tx byte right after each rx_valid
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                rv_prev = 1'b0;
            end else begin
                if (bus.rx_valid) begin
                    check("rx_valid_width", 32'(rv_prev), 32'd0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: got rx_data=%0h with no byte expected", bus.rx_data);
                    end else begin
                        e = sb.pop_front();
                        check("rx_data", 32'(bus.rx_data), 32'(e.data));
                        check("tx_done", 32'(bus.tx_done), 32'(e.done));
                    end
                    rx_idx++;
                    if (rx_idx < int'(cur.n)) begin
                        bus.tx_ready = cur.txv[rx_idx];
                        bus.tx_data  = cur.tx[rx_idx];
                    end else begin
                        bus.tx_ready = 1'b0;
                        bus.tx_data  = 8'h00;
                    end
                end else if (bus.tx_done) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_done_stray: got tx_done=1 without rx_valid, expected 0");
                end
                rv_prev = bus.rx_valid;
            end
        end
    endtask

    // Master: mosi changes with sclk low, miso sampled just before each rise
    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            clks(HALF);
            got[i] = miso;
            sclk = 1'b1;
            clks(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic start_frame(input frame_t f);
        cur          = f;
        rx_idx       = 0;
        bus.tx_ready = 1'b0;
        bus.tx_data  = 8'h00;
        cs_n         = 1'b0;
        clks(2);
    endtask

    task automatic end_frame();
        clks(HALF);
        cs_n = 1'b1;
        clks(SYNC + 4);
    endtask

    task automatic run_frame(input frame_t f);
        logic [7:0] got, expm;
        logic       v;
        exp_t       e;
        start_frame(f);
        for (int k = 0; k < int'(f.n); k++) begin
            v    = (k > 0) && f.txv[k];
            expm = v ? f.tx[k] : FILL;
            e.data = f.mosi[k];
            e.done = v;
            sb.push_back(e);
            send_bits(f.mosi[k], 8, got);
            check("miso_byte", 32'(got), 32'(expm));
            if (k == 0) begin
                check("cs_active_in_frame", 32'(cs_active), 32'd1);
                check("miso_oe_in_frame", 32'(miso_oe), 32'd1);
            end
        end
        end_frame();
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("rx_hold", 32'(bus.rx_data), 32'(f.mosi[int'(f.n) - 1]));
        check("cs_active_after", 32'(cs_active), 32'd0);
        check("miso_oe_after", 32'(miso_oe), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        logic [7:0] got;
        tbl[0] = mk(1, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        tbl[1] = mk(3, 8'h40, 8'h00, 8'h00, 8'h78, 1'b1, 8'h56, 1'b1);
        tbl[2] = mk(2, 8'h10, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        tbl[3] = mk(3, 8'hC3, 8'h81, 8'h7E, 8'hA5, 1'b1, 8'h99, 1'b0);
        tbl[4] = mk(2, 8'h00, 8'hB6, 8'h00, 8'h01, 1'b1, 8'h00, 1'b0);
        cur          = tbl[0];
        rx_idx       = 0;
        rv_prev      = 1'b0;
        bus.tx_ready = 1'b0;
        bus.tx_data  = 8'h00;
        fork
            monitor();
        join_none

        // Reset with idle pins
        rst = 1'b1;
        clks(3);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_tx_done", 32'(bus.tx_done), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_cs_active", 32'(cs_active), 32'd0);
        rst = 1'b0;
        clks(SYNC + 1);
        check("idle_cs_active", 32'(cs_active), 32'd0);
        clks(4);

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i]);
            clks(4);
        end

        // cs_n rises after 5 bits: nothing delivered, next byte aligned
        start_frame(mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
        send_bits(8'hA5, 5, got);
        clks(2);
        cs_n = 1'b1;
        clks(SYNC + 4);
        check("abort_cs_active", 32'(cs_active), 32'd0);
        check("abort_miso", 32'(miso), 32'd0);
        check("abort_miso_oe", 32'(miso_oe), 32'd0);
        run_frame(mk(1, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));

        // sclk toggling with cs_n high is ignored
        send_bits(8'hFF, 8, got);
        clks(6);
        check("idle_rx_hold", 32'(bus.rx_data), 32'h3C);

        // Reset mid-byte; remainder of that frame is ignored
        start_frame(mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
        send_bits(8'h96, 3, got);
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        check("midrst_rx_data", 32'(bus.rx_data), 32'd0);
        check("midrst_cs_active", 32'(cs_active), 32'd0);
        check("midrst_miso_oe", 32'(miso_oe), 32'd0);
        check("midrst_miso", 32'(miso), 32'd0);
        send_bits(8'h96, 5, got);
        send_bits(8'h55, 8, got);
        clks(4);
        check("post_rst_cs_active", 32'(cs_active), 32'd0);
        cs_n = 1'b1;
        clks(8);
        run_frame(mk(1, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
